// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path.
package btb_pkg;

    localparam int WIDTH   = 31;  // MSB index of full instruction address / target
    localparam int B_WIDTH = 7;   // MSB index of PC bits kept by the BTB (index + tag)
    localparam int INDEX   = 3;   // MSB index of the BTB index field

    localparam int INSTR_BYTES = 4;

    // One queued BTB write: PC slice, target and the valid bit to store.
    typedef struct packed {
        logic [B_WIDTH:0] pc;
        logic [WIDTH:0]   target;
        logic             taken;
    } btb_update_t;

endpackage

// File: rtl/btb_update_unit_if.sv
// Resolve handshake, BTB write port and redirect bundle of the update unit.
interface btb_update_unit_if;
    import btb_pkg::*;

    logic             resolveValid;
    logic             resolveReady;
    logic [WIDTH:0]   branchPC;
    logic             branchTaken;
    logic [WIDTH:0]   branchTarget;
    logic             predTaken;
    logic [WIDTH:0]   predTarget;
    logic             writeBTB;
    logic [B_WIDTH:0] oldPC;
    logic [WIDTH:0]   resolvedTarget;
    logic             takenBranch;
    logic             redirect;
    logic [WIDTH:0]   redirectPC;
    logic [15:0]      mispredictCount;

    // Branch ALU / BTB side.
    modport master (
        output resolveValid, branchPC, branchTaken, branchTarget, predTaken, predTarget,
        input  resolveReady, writeBTB, oldPC, resolvedTarget, takenBranch,
        input  redirect, redirectPC, mispredictCount
    );

    // Update unit side.
    modport slave (
        input  resolveValid, branchPC, branchTaken, branchTarget, predTaken, predTarget,
        output resolveReady, writeBTB, oldPC, resolvedTarget, takenBranch,
        output redirect, redirectPC, mispredictCount
    );

endinterface

// File: rtl/update_fifo.sv
// Small synchronous FIFO of pending BTB writes; no bypass in either direction.
module update_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  btb_update_t wdata,
    output btb_update_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty when the low bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    btb_update_t mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Head is forced to zero while empty so the write bus idles at zero.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset discards all queued entries.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are live.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/btb_update_unit.sv
// Compares resolved branches with fetch-time predictions, issues fetch
// redirects and queues BTB corrections that drain one per cycle.
module btb_update_unit
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    btb_update_unit_if.slave  bus
);

    logic        accept;
    logic        mispredict;
    logic        need_update;
    logic        fifo_full;
    logic        fifo_empty;
    logic [WIDTH:0] fix_pc;
    btb_update_t push_entry;
    btb_update_t head;

    assign bus.resolveReady = !fifo_full;
    assign accept           = bus.resolveValid && bus.resolveReady;

    // Outcome vs prediction and the entry a correction would write.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        mispredict  = 1'b0;
        need_update = 1'b0;
        fix_pc      = bus.branchPC + (WIDTH+1)'(INSTR_BYTES);
        push_entry  = '{pc: bus.branchPC[B_WIDTH:0], target: bus.branchTarget,
                        taken: bus.branchTaken};
        if (bus.predTaken != bus.branchTaken) begin
            mispredict = 1'b1;
        end else if (bus.branchTaken && bus.predTarget != bus.branchTarget) begin
            mispredict = 1'b1;
        end
        if (bus.branchTaken) begin
            need_update = !bus.predTaken || (bus.predTarget != bus.branchTarget);
        end else begin
            need_update = bus.predTaken;
        end
        if (bus.branchTaken) fix_pc = bus.branchTarget;
    end

    update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && need_update),
        .pop   (!fifo_empty),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The BTB always accepts, so the head is written whenever one exists.
    assign bus.writeBTB       = !fifo_empty;
    assign bus.oldPC          = head.pc;
    assign bus.resolvedTarget = head.target;
    assign bus.takenBranch    = head.taken;

    // One-cycle redirect pulse, correct fetch PC and saturating mispredict count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.redirect        <= 1'b0;
            bus.redirectPC      <= '0;
            bus.mispredictCount <= '0;
        end else begin
            bus.redirect <= accept && mispredict;
            if (accept && mispredict) begin
                bus.redirectPC <= fix_pc;
                if (bus.mispredictCount != 16'hFFFF)
                    bus.mispredictCount <= bus.mispredictCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_unit.sv
// Self-checking bench: directed cases with literal expectations plus random
// traffic checked every cycle against a queue-based model.
module tb_btb_update_unit;
    import btb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    btb_update_unit_if bus ();

    btb_update_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the outputs must show after the next posedge.
    btb_update_t exp_q[$];
    logic        exp_redirect = 1'b0;
    logic [31:0] exp_rpc      = '0;
    int          exp_cnt      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One stimulus cycle: drive at negedge, then advance the model by one edge.
    task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tg,
                        input logic ptk, input logic [31:0] ptg);
        logic acc, mis, need;
        @(negedge clk);
        reset            = rst;
        bus.resolveValid = v;
        bus.branchPC     = pc;
        bus.branchTaken  = tk;
        bus.branchTarget = tg;
        bus.predTaken    = ptk;
        bus.predTarget   = ptg;
        if (rst) begin
            exp_q.delete();
            exp_redirect = 1'b0;
            exp_rpc      = '0;
            exp_cnt      = 0;
        end else begin
            acc  = v && (exp_q.size() < DEPTH);
            mis  = acc && ((ptk != tk) || (tk && ptg != tg));
            need = acc && (tk ? !(ptk && ptg == tg) : ptk);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (need) exp_q.push_back('{pc: pc[7:0], target: tg, taken: tk});
            exp_redirect = mis;
            if (mis) begin
                exp_rpc = tk ? tg : pc + 32'd4;
                if (exp_cnt < 65535) exp_cnt++;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Compare process: DUT against the model just after each active edge.
    always @(posedge clk) begin
        #1;
        check("resolveReady", 64'(bus.resolveReady), 64'(exp_q.size() < DEPTH));
        check("writeBTB", 64'(bus.writeBTB), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("oldPC", 64'(bus.oldPC), 64'(exp_q[0].pc));
            check("resolvedTarget", 64'(bus.resolvedTarget), 64'(exp_q[0].target));
            check("takenBranch", 64'(bus.takenBranch), 64'(exp_q[0].taken));
        end
        check("redirect", 64'(bus.redirect), 64'(exp_redirect));
        if (exp_redirect) check("redirectPC", 64'(bus.redirectPC), 64'(exp_rpc));
        check("mispredictCount", 64'(bus.mispredictCount), 64'(exp_cnt));
    end

    initial begin
        logic [31:0] pc, tg, ptg;
        logic        tk, ptk, v, rst;
        logic [31:0] targets [4];

        bus.resolveValid = 1'b0;
        bus.branchPC     = '0;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = '0;
        bus.predTaken    = 1'b0;
        bus.predTarget   = '0;

        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle();
        settle();
        check("lit reset ready", 64'(bus.resolveReady), 64'd1);
        check("lit reset write", 64'(bus.writeBTB), 64'd0);
        check("lit reset redirect", 64'(bus.redirect), 64'd0);
        check("lit reset count", 64'(bus.mispredictCount), 64'd0);

        // Taken branch not predicted: redirect and BTB write land together.
        step(1'b0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
        settle();
        check("lit t1 redirect", 64'(bus.redirect), 64'd1);
        check("lit t1 redirectPC", 64'(bus.redirectPC), 64'h200);
        check("lit t1 write", 64'(bus.writeBTB), 64'd1);
        check("lit t1 oldPC", 64'(bus.oldPC), 64'h04);
        check("lit t1 target", 64'(bus.resolvedTarget), 64'h200);
        check("lit t1 taken", 64'(bus.takenBranch), 64'd1);
        check("lit t1 count", 64'(bus.mispredictCount), 64'd1);
        idle();
        settle();
        check("lit t1 pulse end", 64'(bus.redirect), 64'd0);
        check("lit t1 popped", 64'(bus.writeBTB), 64'd0);

        // Predicted taken, actually not taken.
        step(1'b0, 1'b1, 32'h104, 1'b0, 32'h300, 1'b1, 32'h200);
        settle();
        check("lit t2 redirectPC", 64'(bus.redirectPC), 64'h108);
        check("lit t2 taken", 64'(bus.takenBranch), 64'd0);
        check("lit t2 count", 64'(bus.mispredictCount), 64'd2);

        // Correct taken prediction with matching target: nothing happens.
        step(1'b0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 32'h200);
        settle();
        check("lit t3 redirect", 64'(bus.redirect), 64'd0);
        check("lit t3 write", 64'(bus.writeBTB), 64'd0);

        // DEPTH+1 back-to-back updates drain in order, one per cycle.
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i), 1'b0, 32'h0);
            settle();
            check("lit burst ready", 64'(bus.resolveReady), 64'd1);
            check("lit burst oldPC", 64'(bus.oldPC), 64'(8'(i * 4)));
            check("lit burst target", 64'(bus.resolvedTarget), 64'(32'h2000 + 32'(i)));
        end
        idle();

        // Fall-through wraps at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        settle();
        check("lit wrap redirectPC", 64'(bus.redirectPC), 64'h0);
        idle();

        // Reset with a queued entry and a pending redirect.
        step(1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h504, 1'b1, 32'h700, 1'b0, 32'h0);
        settle();
        check("lit rst write", 64'(bus.writeBTB), 64'd0);
        check("lit rst redirect", 64'(bus.redirect), 64'd0);
        check("lit rst ready", 64'(bus.resolveReady), 64'd1);
        check("lit rst count", 64'(bus.mispredictCount), 64'd0);

        // Random traffic with predictions biased towards being right.
        targets = '{32'h0000_0200, 32'h0000_0400, 32'h8000_0000, 32'hFFFF_FFF0};
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 3) != 0);
            pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            tk  = $urandom_range(0, 1) == 1;
            tg  = targets[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) begin
                ptk = tk;
                ptg = tg;
            end else begin
                ptk = $urandom_range(0, 1) == 1;
                ptg = targets[$urandom_range(0, 3)];
            end
            step(rst, v, pc, tk, tg, ptk, ptg);
        end
        idle();
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
